sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_mem.sv | 48 ++++
 rtl/sync_fifo.sv | 140 ++++++++++++++
 tb/tb_sync_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared constants and helpers for the synchronous FIFO.
//   Contents:
//     DEFAULT_DATA_WIDTH  default word width in bits
//     DEFAULT_DEPTH       default number of storage entries (power of two, >= 2)
//     ptr_width(depth)    address/pointer width needed to index 'depth' entries
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Pointer width for a power-of-two depth. The occupancy count needs one
  // more bit than this so that "exactly DEPTH entries" is representable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//   DEPTH x DATA_WIDTH storage with one write port and one registered read
//   port, written so that it maps onto an inferred block RAM.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset; clears rd_data only
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_en    in   read strobe; loads rd_data from mem[rd_addr]
//     rd_addr  in   read address
//     rd_data  out  registered read data, holds when rd_en is low
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The array itself is never reset so it stays a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register with synchronous reset (maps onto the RAM output latch).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-in first-out buffer with registered read data
//   (one-cycle read latency) and combinational full/empty from the count.
//   Optional feature: define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow
//   and underflow outputs.
//   Parameters:
//     DATA_WIDTH  word width in bits
//     DEPTH       number of entries, power of two and >= 2
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset (pointers, count, dout)
//     wr_en      in   write request, ignored while full
//     din        in   write data
//     rd_en      in   read request, ignored while empty
//     dout       out  registered read data, holds when no read is accepted
//     full       out  DEPTH entries held
//     empty      out  no entries held
//     overflow   out  (SYNC_FIFO_ERR_FLAGS_EN) sticky: write attempted while full
//     underflow  out  (SYNC_FIFO_ERR_FLAGS_EN) sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_next;

  logic wr_accept;
  logic rd_accept;
  logic mem_wr_en;
  logic mem_rd_en;

  // Flags come straight from the registered count, so they always reflect
  // pre-edge state when deciding which requests are accepted.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Reset wins over traffic: keep the RAM from taking a write in a reset cycle.
  assign mem_wr_en = wr_accept && !rst;
  assign mem_rd_en = rd_accept && !rst;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (wr_accept) begin
      wr_ptr_next = wr_ptr + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr + PTR_W'(1);
    end
    // Simultaneous accepted read and write leave the count unchanged.
    if (wr_accept && !rd_accept) begin
      count_next = count + CNT_W'(1);
    end else if (rd_accept && !wr_accept) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (mem_rd_en),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // Any request that hits a blocking flag counts, even when the opposite
  // request on the same edge is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Directed self-checking bench for sync_fifo (DATA_WIDTH=8, DEPTH=16).
//   Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int errors = 0;
  int checks = 0;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [DW-1:0] ref_q [$];
  logic [DW-1:0] exp_dout;
  logic [DW-1:0] wdata;

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    // ---------------- reset ----------------
    do_reset();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    chk("reset_rd_ptr", 32'(dut.rd_ptr), 32'd0);
    $display("reset: empty=%0d full=%0d dout=0x%0h", empty, full, dout);

    // ---------------- fill: 20 writes, 16 accepted ----------------
    for (int i = 1; i <= 20; i++) begin
      wr_en = 1'b1;
      din   = DW'(i);
      tick();
      chk($sformatf("fill%0d_full", i), 32'(full), (i >= 16) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_empty", i), 32'(empty), 32'd0);
      chk($sformatf("fill%0d_count", i), 32'(dut.count), (i >= 16) ? 32'd16 : 32'(i));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk($sformatf("fill%0d_overflow", i), 32'(overflow), (i >= 17) ? 32'd1 : 32'd0);
`endif
      $display("write din=0x%0h full=%0d", din, full);
    end
    wr_en = 1'b0;

    // ---------------- drain: 20 reads, 16 accepted ----------------
    for (int i = 1; i <= 20; i++) begin
      rd_en = 1'b1;
      tick();
      chk($sformatf("drain%0d_dout", i), 32'(dout), (i <= 16) ? 32'(i) : 32'h10);
      chk($sformatf("drain%0d_empty", i), 32'(empty), (i >= 16) ? 32'd1 : 32'd0);
      chk($sformatf("drain%0d_full", i), 32'(full), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk($sformatf("drain%0d_underflow", i), 32'(underflow), (i >= 17) ? 32'd1 : 32'd0);
`endif
      $display("read dout=0x%0h empty=%0d", dout, empty);
    end
    rd_en = 1'b0;

    // ---------------- boundary: both requests while empty ----------------
    do_reset();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rst_clears_overflow", 32'(overflow), 32'd0);
    chk("rst_clears_underflow", 32'(underflow), 32'd0);
`endif
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'hAA;
    tick();
    chk("both_empty_dout", 32'(dout), 32'd0);
    chk("both_empty_count", 32'(dut.count), 32'd1);
    chk("both_empty_empty", 32'(empty), 32'd0);
    $display("both while empty: dout=0x%0h count=%0d", dout, dut.count);
    rd_en = 1'b0;
    for (int k = 0; k < 15; k++) begin
      din = 8'hB0 + 8'(k);
      tick();
    end
    wr_en = 1'b0;
    chk("prefull_full", 32'(full), 32'd1);

    // ---------------- boundary: both requests while full ----------------
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'hCC;
    tick();
    chk("both_full_dout", 32'(dout), 32'hAA);
    chk("both_full_count", 32'(dut.count), 32'd15);
    chk("both_full_full", 32'(full), 32'd0);
    $display("both while full: dout=0x%0h count=%0d", dout, dut.count);
    wr_en = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("bdrain%0d_dout", k), 32'(dout), 32'h B0 + 32'(k));
      $display("read dout=0x%0h", dout);
    end
    rd_en = 1'b0;
    chk("bdrain_empty", 32'(empty), 32'd1);

    // ---------------- concurrent traffic with reference queue ----------------
    do_reset();
    ref_q.delete();
    exp_dout = '0;
    for (int c = 0; c < 45; c++) begin
      wdata = DW'($urandom_range(0, 255));
      wr_en = (c < 26);
      rd_en = (c >= 5);
      din   = wdata;
      // Expected outcome uses the occupancy before this edge.
      if (rd_en && ref_q.size() != 0) begin
        exp_dout = ref_q.pop_front();
        if (wr_en) ref_q.push_back(wdata);
      end else if (wr_en && ref_q.size() < DP) begin
        ref_q.push_back(wdata);
      end
      tick();
      chk($sformatf("conc%0d_dout", c), 32'(dout), 32'(exp_dout));
      chk($sformatf("conc%0d_empty", c), 32'(empty), (ref_q.size() == 0) ? 32'd1 : 32'd0);
      $display("cycle %0d wr=%0d rd=%0d din=0x%0h dout=0x%0h", c, wr_en, rd_en, din, dout);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("conc_queue_drained", 32'(ref_q.size()), 32'd0);

    // ---------------- mid-operation reset with 8 entries ----------------
    do_reset();
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = 8'h40 + 8'(k);
      tick();
    end
    chk("mid_count_before", 32'(dut.count), 32'd8);
    rd_en = 1'b1;
    din   = 8'h77;
    tick();
    chk("mid_traffic_dout", 32'(dout), 32'h40);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    chk("mid_rst_rd_ptr", 32'(dut.rd_ptr), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    $display("mid reset: empty=%0d full=%0d", empty, full);

    // Fresh data flows normally after the mid-operation reset.
    wr_en = 1'b1;
    din   = 8'h5A;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_rst_dout", 32'(dout), 32'h5A);
    chk("post_rst_empty", 32'(empty), 32'd1);
    $display("post reset read dout=0x%0h", dout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
